// File: rtl/decode_stage_q_if.sv
// Fetch->decode->execute handshake bundle for decode_stage_q.
// The slave modport is the decode stage's view, and the master modport is the driver's view.
interface decode_stage_q_if #(parameter int XLEN = 32);
  logic             flush;
  logic             exception_pending;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_imm;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [33:0]      out_ctrl;

  modport master (
    output flush, exception_pending, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2, out_ctrl
  );
  modport slave (
    input  flush, exception_pending, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2, out_ctrl
  );
endinterface

// File: rtl/decode_stage_q.sv
// Registered RV32I/M decode stage with a DEPTH-entry raw-instruction queue and flush.
// Define MULDIV_EN to decode the M extension; without it, funct7=0000001 OP encodings are illegal.
module decode_stage_q #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  decode_stage_q_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_R = 7'b0110011,
                         OP_SYS = 7'b1110011, OP_FENCE = 7'b0001111;

  logic [DEPTH-1:0][XLEN-1:0] r_q_pc;
  logic [DEPTH-1:0][31:0]     r_q_ins;
  logic [PW-1:0]              r_wr, r_rd;
  logic [CW-1:0]              r_cnt;

  logic            r_vld;
  logic [XLEN-1:0] r_pc, r_imm;
  logic [4:0]      r_rd_idx, r_rs1, r_rs2;
  logic [33:0]     r_ctrl;

  logic            w_in_ready, w_has_q, w_in_fire, w_ld, w_pop, w_bypass, w_push;
  logic [31:0]     w_ins;
  logic [XLEN-1:0] w_pc;

  assign w_in_ready = (r_cnt < FULL);
  assign w_has_q    = (r_cnt != '0);
  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_ld       = (!r_vld | bus.out_ready) & (w_has_q | w_in_fire);
  assign w_pop      = w_ld & w_has_q;
  assign w_bypass   = w_ld & !w_has_q;
  assign w_push     = w_in_fire & !w_bypass;

  // Queue head has priority; an empty queue lets the live input bypass straight to the output.
  assign w_ins = w_has_q ? r_q_ins[r_rd] : bus.in_instr;
  assign w_pc  = w_has_q ? r_q_pc[r_rd]  : bus.in_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_pc  <= '0;
      r_q_ins <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
    end else if (bus.flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_q_pc[r_wr]  <= bus.in_pc;
        r_q_ins[r_wr] <= bus.in_instr;
        r_wr          <= r_wr + PW'(1);
      end
      if (w_pop) r_rd <= r_rd + PW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

  // ---------------- decoder ----------------
  logic [6:0] w_op, w_f7;
  logic [2:0] w_f3;
  assign w_op = w_ins[6:0];
  assign w_f3 = w_ins[14:12];
  assign w_f7 = w_ins[31:25];

  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt;
  assign w_imm_i = {{(XLEN-11){w_ins[31]}}, w_ins[30:20]};
  assign w_imm_s = {{(XLEN-11){w_ins[31]}}, w_ins[30:25], w_ins[11:7]};
  assign w_imm_b = {{(XLEN-12){w_ins[31]}}, w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-31){w_ins[31]}}, w_ins[30:12], 12'b0};
  assign w_imm_j = {{(XLEN-20){w_ins[31]}}, w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};

  logic w_sl_ok, w_sr_ok;
  always_comb begin
    if (XLEN == 64) begin
      w_shamt = XLEN'(w_ins[25:20]);
      w_sl_ok = (w_ins[31:26] == 6'b0);
      w_sr_ok = (w_ins[31:26] == 6'b0) || (w_ins[31:26] == 6'b010000);
    end else begin
      w_shamt = XLEN'(w_ins[24:20]);
      w_sl_ok = (w_f7 == 7'b0);
      w_sr_ok = (w_f7 == 7'b0) || (w_f7 == 7'b0100000);
    end
  end

  logic [1:0]      d_bsel, d_pcsel;
  logic            d_we, d_csr_we, d_j, d_jr, d_bneq, d_btype, d_lui, d_auipc;
  logic            d_ecall, d_ebreak, d_uret, d_sret, d_mret, d_wfi, d_ill;
  logic [2:0]      d_fn;
  logic [3:0]      d_alu, d_mem, d_md;
  logic [XLEN-1:0] d_imm;
  logic [33:0]     w_ctrl;

  always_comb begin
    d_bsel = 2'b00; d_pcsel = 2'b00; d_we = 1'b0; d_csr_we = 1'b0;
    d_j = 1'b0; d_jr = 1'b0; d_bneq = 1'b0; d_btype = 1'b0; d_lui = 1'b0; d_auipc = 1'b0;
    d_ecall = 1'b0; d_ebreak = 1'b0; d_uret = 1'b0; d_sret = 1'b0; d_mret = 1'b0;
    d_wfi = 1'b0; d_ill = 1'b0;
    d_fn = 3'b000; d_alu = 4'b0000; d_mem = 4'b0000; d_md = 4'b0000;
    d_imm = '0;
    case (w_op)
      OP_LUI:   begin d_we = 1'b1; d_lui = 1'b1; d_fn = 3'b011; d_imm = w_imm_u; end
      OP_AUIPC: begin d_we = 1'b1; d_auipc = 1'b1; d_fn = 3'b101; d_imm = w_imm_u; end
      OP_JAL:   begin d_we = 1'b1; d_j = 1'b1; d_fn = 3'b001; d_pcsel = 2'b10; d_imm = w_imm_j; end
      OP_JALR: begin
        d_ill = (w_f3 != 3'b000);
        d_we = 1'b1; d_jr = 1'b1; d_fn = 3'b001; d_pcsel = 2'b10; d_bsel = 2'b01;
        d_imm = w_imm_i;
      end
      OP_BR: begin
        d_ill = (w_f3 == 3'b010) || (w_f3 == 3'b011);
        d_btype = 1'b1; d_pcsel = 2'b10; d_imm = w_imm_b;
        d_bneq = (w_f3 == 3'b001);
        case (w_f3)
          3'b100:  d_alu = 4'b0010;
          3'b101:  d_alu = 4'b1001;
          3'b110:  d_alu = 4'b0011;
          3'b111:  d_alu = 4'b1010;
          default: d_alu = 4'b1000;
        endcase
      end
      OP_LD: begin
        d_we = 1'b1; d_fn = 3'b100; d_bsel = 2'b01; d_imm = w_imm_i;
        case (w_f3)
          3'b000:  d_mem = 4'b0101;
          3'b001:  d_mem = 4'b0011;
          3'b010:  d_mem = 4'b0111;
          3'b100:  d_mem = 4'b0100;
          3'b101:  d_mem = 4'b0010;
          default: d_ill = 1'b1;
        endcase
      end
      OP_ST: begin
        d_bsel = 2'b01; d_imm = w_imm_s;
        case (w_f3)
          3'b000:  d_mem = 4'b1101;
          3'b001:  d_mem = 4'b1011;
          3'b010:  d_mem = 4'b1111;
          default: d_ill = 1'b1;
        endcase
      end
      OP_IMM: begin
        d_we = 1'b1; d_alu = {1'b0, w_f3};
        if (w_f3 == 3'b001) begin
          d_bsel = 2'b10; d_imm = w_shamt; d_ill = !w_sl_ok;
        end else if (w_f3 == 3'b101) begin
          d_bsel = 2'b10; d_imm = w_shamt; d_ill = !w_sr_ok;
          d_alu = {w_ins[30], w_f3};
        end else begin
          d_bsel = 2'b01; d_imm = w_imm_i;
        end
      end
      OP_R: begin
        d_we = 1'b1;
        if (w_f7 == 7'b0000000) d_alu = {1'b0, w_f3};
        else if (w_f7 == 7'b0100000) begin
          if (w_f3 == 3'b000)      d_alu = 4'b1000;
          else if (w_f3 == 3'b101) d_alu = 4'b1101;
          else                     d_ill = 1'b1;
        end else if (w_f7 == 7'b0000001) begin
`ifdef MULDIV_EN
          d_fn = 3'b010;
          case (w_f3)
            3'b000:  d_md = 4'b0011;
            3'b001:  d_md = 4'b0101;
            3'b010:  d_md = 4'b0110;
            3'b011:  d_md = 4'b0111;
            3'b100:  d_md = 4'b1001;
            3'b101:  d_md = 4'b1011;
            3'b110:  d_md = 4'b1101;
            default: d_md = 4'b1111;
          endcase
`else
          d_ill = 1'b1;
`endif
        end else d_ill = 1'b1;
      end
      OP_SYS: begin
        // The exception flag is sampled here so it travels with the bundle it suppressed.
        d_fn = 3'b110; d_csr_we = 1'b1; d_we = !bus.exception_pending; d_imm = w_imm_i;
        d_ecall  = (w_ins == 32'h0000_0073);
        d_ebreak = (w_ins == 32'h0010_0073);
        d_uret   = (w_ins == 32'h0020_0073);
        d_sret   = (w_ins == 32'h1020_0073);
        d_mret   = (w_ins == 32'h3020_0073);
        d_wfi    = (w_ins == 32'h1050_0073);
      end
      OP_FENCE: ;
      default: d_ill = (w_ins != 32'h0);
    endcase
    if (d_ill) begin
      d_bsel = 2'b00; d_pcsel = 2'b00; d_we = 1'b0; d_csr_we = 1'b0;
      d_j = 1'b0; d_jr = 1'b0; d_bneq = 1'b0; d_btype = 1'b0; d_lui = 1'b0; d_auipc = 1'b0;
      d_ecall = 1'b0; d_ebreak = 1'b0; d_uret = 1'b0; d_sret = 1'b0; d_mret = 1'b0;
      d_wfi = 1'b0; d_fn = 3'b000; d_alu = 4'b0000; d_mem = 4'b0000; d_md = 4'b0000;
      d_imm = '0;
    end
  end

  assign w_ctrl = {d_ill, d_wfi, d_mret, d_sret, d_uret, d_ebreak, d_ecall, d_auipc, d_lui,
                   d_btype, d_bneq, d_jr, d_j, d_pcsel, d_md, d_mem, d_alu, d_fn,
                   d_csr_we, d_we, d_bsel};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld    <= 1'b0;
      r_pc     <= '0;
      r_imm    <= '0;
      r_rd_idx <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_ctrl   <= '0;
    end else if (bus.flush) begin
      r_vld <= 1'b0;
    end else if (w_ld) begin
      r_vld    <= 1'b1;
      r_pc     <= w_pc;
      r_imm    <= d_imm;
      r_rd_idx <= w_ins[11:7];
      r_rs1    <= w_ins[19:15];
      r_rs2    <= w_ins[24:20];
      r_ctrl   <= w_ctrl;
    end else if (bus.out_ready) begin
      r_vld <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld;
  assign bus.out_pc    = r_pc;
  assign bus.out_imm   = r_imm;
  assign bus.out_rd    = r_rd_idx;
  assign bus.out_rs1   = r_rs1;
  assign bus.out_rs2   = r_rs2;
  assign bus.out_ctrl  = r_ctrl;
endmodule

// File: doc/decode_stage_q.md
Name: decode_stage_q

Overview:
- Registered RV32I/M decode stage with a DEPTH-entry raw-instruction queue and valid/ready handshakes on both sides.
- Sits between fetch and execute. Accepts {pc, instr} from fetch and presents a registered decoded control bundle, immediate and register indices to execute.
- Adds over the combinational decoder: XLEN-wide immediate generation, strict illegal-encoding detection, backpressure buffering and flush.

Parameters:
XLEN, 32, datapath/pc/immediate width (32 or 64)
DEPTH, 2, raw queue entries; power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  drop queue and output register (branch/trap redirect)
exception_pending  in  1  from commit; suppresses SYSTEM write-back
in_valid  in  1  fetch offers in_pc/in_instr
in_ready  out  1  queue can accept
in_pc  in  XLEN  instruction pc
in_instr  in  32  raw instruction word
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_pc  out  XLEN  pc of decoded instruction
out_imm  out  XLEN  sign-extended immediate
out_rd/out_rs1/out_rs2  out  5 each  register indices, instr[11:7]/[19:15]/[24:20]
out_ctrl  out  34  control bundle, layout in Behaviour

Behaviour:
- Reset (async, rst=1): queue count=0, pointers=0, out_valid=0, out_pc/out_imm/out_rd/out_rs1/out_rs2/out_ctrl all 0. in_ready=1 from the first cycle after reset release.
- Handshake:
  - Input transfer when in_valid&in_ready. in_ready = (count<DEPTH). Ready must not depend on in_valid.
  - Output transfer when out_valid&out_ready. The output register loads when (!out_valid | out_ready) and a source exists.
  - Source priority: queue head if count>0, else the same-cycle input (bypass).
  - Latency 1 cycle (accept at N, out_valid at N+1). Sustained throughput 1/cycle. out_* are stable while out_valid&!out_ready.
- Queue:
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - At full, a pop frees a slot for the next cycle only; no same-cycle push-on-full.
  - A bypassed input never enters the queue.
- flush: next cycle count=0 and out_valid=0. Any same-cycle input or output load is discarded. Flush dominates all other events.
- exception_pending is sampled when the output register loads and is held with the bundle.
- out_ctrl layout (LSB first):
  - [1:0] b_sel: 01 = I-arith non-shift / jalr / load / store; 10 = slli/srli/srai
  - [2] we; [3] csr_we; [6:4] fn; [10:7] alu_fn; [14:11] mem_op; [18:15] muldiv_op; [20:19] pcselect
  - [21] j; [22] jr; [23] bneq; [24] btype; [25] lui; [26] auipc
  - [27] ecall; [28] ebreak; [29] uret; [30] sret; [31] mret; [32] wfi; [33] illegal_instr
- fn encoding: 000 alu, 001 jal/jalr (pc+4), 010 muldiv, 011 lui, 100 load, 101 auipc, 110 system.
- alu_fn encoding: add/addi/jalr=0000, sll=0001, slt/blt=0010, sltu/bltu=0011, xor=0100, srl=0101, or=0110, and=0111, sub/beq/bne=1000, bge=1001, bgeu=1010, sra=1101.
- mem_op encoding: SW 1111, SH 1011, SB 1101, LW 0111, LH 0011, LHU 0010, LB 0101, LBU 0100, none 0000.
- muldiv_op encoding: MUL 0011, MULH 0101, MULHU 0111, MULHSU 0110, DIV 1001, DIVU 1011, REM 1101, REMU 1111.
- pcselect = 10 for branch/jal/jalr, else 00.
- we = rtype | itype | jal | jalr | load | lui | auipc | (system & !exception_pending_sampled).
- Illegal encodings:
  - unknown opcode
  - R-type funct7 not in {0000000, 0100000 (add/sub/srl/sra only), 0000001 (M)}
  - branch funct3 010/011
  - load funct3 011/110/111
  - store funct3 >010
  - jalr funct3 !=000
  - slli/srli funct7 !=0; srai funct7 !=0100000 (XLEN=64: upper 6 bits, shamt 6 bits)
  - For any illegal encoding, out_ctrl = only bit 33 set; imm = 0.
- All-zero instruction word: legal nop, out_ctrl=0.
- Immediates: I/S/B/U/J formats, sign-extended from bit 31 to XLEN. Shift-imm gives zero-extended shamt.

Optional Feature:
- MULDIV_EN defined: funct7=0000001 R-type decodes to muldiv_op with fn=010.
- MULDIV_EN not defined: those encodings set illegal_instr and muldiv_op is constant 0.

Test Plan:
- Reset mid-stream with queue full (DEPTH=2): assert rst -> out_valid=0, out_ctrl=0 immediately; in_ready=1 after release.
- Back-to-back addi x1,x0,-1 (0xFFF00093) with out_ready=1 -> out_valid one cycle after accept; imm=0xFFFFFFFF; b_sel=01; we=1; fn=000; one result per cycle.
- Hold out_ready=0 while feeding 4 instructions -> exactly 3 accepted (2 queued + 1 output); in_ready=0 thereafter. Release -> in-order drain, no loss or duplication.
- flush asserted on the same cycle as in_valid=1 with queue full -> next cycle out_valid=0, count=0; the flushed input never appears.
- 0x02208033 (mul x0,x1,x2): with MULDIV_EN -> muldiv_op=0011, fn=010; without -> illegal_instr=1, we=0. 0xFE208033 -> illegal in both builds.
- ecall (0x00000073) with exception_pending=1 at load -> ecall=1, csr_we=1, we=0, fn=110. With exception_pending=0 -> we=1.
